dallanma_guncelleme_denetleyici: RTL
====================================

DALLANMA_GUNCELLEME_DENETLEYICI -- requirements
Module: dallanma_guncelleme_denetleyici

Interface
REQ-001 The module SHALL have parameter FIFO_DERINLIK, default 4, giving the update FIFO depth in entries; legal values are powers of two, at least 2.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port a_gecerli_i, input, 1 bit: requester A (branch unit) holds a resolved branch.
REQ-005 The module SHALL have ports a_atladi_i (input, 1 bit, taken), a_ps_i (input, 32 bits, branch PC) and a_hedef_i (input, 32 bits, target address), all for requester A.
REQ-006 The module SHALL have port a_hazir_o, input-side handshake output, 1 bit: the A entry is accepted this cycle.
REQ-007 The module SHALL have ports b_gecerli_i, b_atladi_i, b_ps_i[31:0], b_hedef_i[31:0] and b_hazir_o: requester B (jump unit), with the same meaning as A.
REQ-008 The module SHALL have port durdur_i, input, 1 bit: predictor update is blocked this cycle.
REQ-009 The module SHALL have port dallanma_hata_i, input, 1 bit: a misprediction pulse, used only by the statistics counters.
REQ-010 The module SHALL have ports guncelle_gecerli_o (1 bit), guncelle_atladi_o (1 bit), guncelle_ps_o (32 bits) and guncelle_hedef_adresi_o (32 bits), all outputs driving the predictor update port.
REQ-011 The module SHALL have ports bos_o and dolu_o, outputs, 1 bit each: FIFO empty and FIFO full.
REQ-012 The module SHALL have ports toplam_o, atladi_sayisi_o and hata_sayisi_o, outputs, 32 bits each: statistics counters (see Configuration).

Function
REQ-013 The module SHALL hold an occupancy count of $clog2(FIFO_DERINLIK)+1 bits; free space = FIFO_DERINLIK - count, computed before any same-cycle pop (no pop credit).
REQ-014 With free >= 2, the module SHALL drive a_hazir_o = b_hazir_o = 1.
REQ-015 With free == 1, the module SHALL set a_hazir_o = !b_gecerli_i || oncelik_r==A and b_hazir_o = !a_gecerli_i || oncelik_r==B.
REQ-016 With free == 0, the module SHALL drive both hazir outputs to 0.
REQ-017 The module SHALL treat an entry as accepted exactly when gecerli_i && hazir_o; no other input affects hazir.
REQ-018 When both requesters are accepted in the same cycle, the module SHALL write A then B into consecutive slots, with A older.
REQ-019 The module SHALL toggle oncelik_r only when free == 1, both requesters are valid, and the priority holder is granted; otherwise oncelik_r holds.
REQ-020 The module SHALL set guncelle_gecerli_o = !bos_o && !durdur_i, and drive guncelle_atladi_o, guncelle_ps_o and guncelle_hedef_adresi_o from the FIFO head.
REQ-021 The module SHALL drive guncelle_atladi_o, guncelle_ps_o and guncelle_hedef_adresi_o to 0 whenever guncelle_gecerli_o is 0.
REQ-022 The module SHALL pop the head entry when guncelle_gecerli_o is 1, draining at most one entry per cycle.
REQ-023 An entry accepted in cycle N SHALL appear on the update port no earlier than cycle N+1; there is no combinational bypass.
REQ-024 A push and a pop in the same cycle SHALL leave count equal to count + pushes - 1.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DERINLIK.
REQ-026 The module SHALL derive bos_o (count == 0) and dolu_o (count == FIFO_DERINLIK) from the registered count only.
REQ-027 Entries SHALL leave the FIFO in strict acceptance order and SHALL never be dropped or duplicated.

Reset
REQ-028 While rst_i == 0 at a clock edge, the module SHALL clear count and both pointers, set oncelik_r = A, and clear all counters.
REQ-029 During and after reset, outputs SHALL be guncelle_gecerli_o = 0, bos_o = 1, dolu_o = 0, and both hazir = 1 once rst_i == 1.
REQ-030 Entries pending at reset mid-operation SHALL be discarded; no update issues in the first cycle after reset.
REQ-031 FIFO data storage need not be reset.

Configuration
REQ-032 With macro DALLANMA_SAYAC_EN defined, the module SHALL increment toplam_o on every pop, atladi_sayisi_o on every pop with guncelle_atladi_o == 1, and hata_sayisi_o on every cycle with dallanma_hata_i == 1.
REQ-033 With DALLANMA_SAYAC_EN defined, all three counters SHALL saturate at 32'hFFFF_FFFF.
REQ-034 Without DALLANMA_SAYAC_EN, the module SHALL tie toplam_o, atladi_sayisi_o and hata_sayisi_o to 0 and synthesize no counter registers.

Verification
REQ-035 Verification SHALL cover single entry: A pushes ps=0x100, hedef=0x200, taken -> next cycle guncelle_gecerli_o=1, ps=0x100, hedef=0x200, atladi=1, then bos_o=1.
REQ-036 Verification SHALL cover simultaneous push: A ps=0x10 and B ps=0x20 in the same cycle with an empty FIFO -> both hazir=1, and drain order is 0x10 then 0x20 on consecutive cycles.
REQ-037 Verification SHALL cover the contested last slot: count=3, durdur_i=1, both valid -> only A accepted and oncelik_r becomes B; after one pop with both still valid -> B accepted.
REQ-038 Verification SHALL cover full plus stall: durdur_i=1 with 4 pushes -> dolu_o=1 and both hazir=0; release durdur_i -> 4 consecutive updates in order, with no drop or duplicate.
REQ-039 Verification SHALL cover reset mid-operation: rst_i=0 for 1 cycle with count=2 -> next cycle bos_o=1 and guncelle_gecerli_o=0.
REQ-040 Verification SHALL cover the counters: with DALLANMA_SAYAC_EN, 5 pops (3 taken) and 2 dallanma_hata_i pulses -> toplam_o=5, atladi_sayisi_o=3, hata_sayisi_o=2; without the macro, all three read 0.

Source files
------------

// File: rtl/dallanma_guncelleme_denetleyici.sv
// rtl/dallanma_guncelleme_denetleyici.sv - two-requester branch predictor update FIFO with optional statistics
//
// Purpose:
//   Collects resolved branches from requester A (branch unit) and requester B
//   (jump unit) into a small in-order FIFO and replays them one per cycle onto
//   the predictor update port whenever the predictor is not stalled.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-low reset
//   a_* / b_*                    requester A / B: gecerli (valid), atladi (taken),
//                                ps (branch PC), hedef (target), hazir (accepted)
//   durdur_i                     blocks predictor update this cycle
//   dallanma_hata_i              misprediction pulse, statistics only
//   guncelle_*_o                 predictor update port, driven from FIFO head
//   bos_o, dolu_o                FIFO empty / full
//   toplam_o, atladi_sayisi_o,
//   hata_sayisi_o                statistics counters
//
// Configuration:
//   DALLANMA_SAYAC_EN            when defined, builds saturating statistics
//                                counters; otherwise the counter outputs are 0.

module dallanma_guncelleme_denetleyici #(
  parameter int FIFO_DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_gecerli_i,
  input  logic        a_atladi_i,
  input  logic [31:0] a_ps_i,
  input  logic [31:0] a_hedef_i,
  output logic        a_hazir_o,
  input  logic        b_gecerli_i,
  input  logic        b_atladi_i,
  input  logic [31:0] b_ps_i,
  input  logic [31:0] b_hedef_i,
  output logic        b_hazir_o,
  input  logic        durdur_i,
  input  logic        dallanma_hata_i,
  output logic        guncelle_gecerli_o,
  output logic        guncelle_atladi_o,
  output logic [31:0] guncelle_ps_o,
  output logic [31:0] guncelle_hedef_adresi_o,
  output logic        bos_o,
  output logic        dolu_o,
  output logic [31:0] toplam_o,
  output logic [31:0] atladi_sayisi_o,
  output logic [31:0] hata_sayisi_o
);

  localparam int PW = $clog2(FIFO_DERINLIK);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        atladi;
    logic [31:0] ps;
    logic [31:0] hedef;
  } giris_t;

  typedef enum logic {
    ONC_A = 1'b0,
    ONC_B = 1'b1
  } oncelik_t;

  logic [CW-1:0] sayac_q, sayac_d;
  logic [PW-1:0] yaz_ptr_q, yaz_ptr_d;
  logic [PW-1:0] oku_ptr_q, oku_ptr_d;
  logic [PW-1:0] yaz_b_ptr;
  oncelik_t      oncelik_q, oncelik_d;
  giris_t        kayit_q [FIFO_DERINLIK];
  giris_t        kayit_d [FIFO_DERINLIK];
  giris_t        bas;

  logic [CW-1:0] bos_yer;
  logic          a_kabul, b_kabul, cek;

  // Free space is taken from the registered count only; a pop in the same
  // cycle does not create room for a push.
  assign bos_yer = CW'(FIFO_DERINLIK) - sayac_q;
  assign bos_o   = (sayac_q == '0);
  assign dolu_o  = (sayac_q == CW'(FIFO_DERINLIK));

  always_comb begin
    a_hazir_o = 1'b0;
    b_hazir_o = 1'b0;
    oncelik_d = oncelik_q;
    if (bos_yer >= CW'(2)) begin
      a_hazir_o = 1'b1;
      b_hazir_o = 1'b1;
    end else if (bos_yer == CW'(1)) begin
      // One slot left: an uncontested requester takes it, otherwise the
      // priority holder wins and priority passes to the other side.
      a_hazir_o = !b_gecerli_i || (oncelik_q == ONC_A);
      b_hazir_o = !a_gecerli_i || (oncelik_q == ONC_B);
      if (a_gecerli_i && b_gecerli_i) begin
        oncelik_d = (oncelik_q == ONC_A) ? ONC_B : ONC_A;
      end
    end
  end

  assign a_kabul = a_gecerli_i && a_hazir_o;
  assign b_kabul = b_gecerli_i && b_hazir_o;

  // B lands right behind A when both are accepted, so A is the older entry.
  assign yaz_b_ptr = yaz_ptr_q + PW'(a_kabul);

  assign bas = kayit_q[oku_ptr_q];
  assign cek = !bos_o && !durdur_i;

  assign guncelle_gecerli_o      = cek;
  assign guncelle_atladi_o       = cek ? bas.atladi : 1'b0;
  assign guncelle_ps_o           = cek ? bas.ps     : 32'd0;
  assign guncelle_hedef_adresi_o = cek ? bas.hedef  : 32'd0;

  always_comb begin
    kayit_d = kayit_q;
    if (a_kabul) begin
      kayit_d[yaz_ptr_q] = '{atladi: a_atladi_i, ps: a_ps_i, hedef: a_hedef_i};
    end
    if (b_kabul) begin
      kayit_d[yaz_b_ptr] = '{atladi: b_atladi_i, ps: b_ps_i, hedef: b_hedef_i};
    end
  end

  always_comb begin
    yaz_ptr_d = yaz_ptr_q + PW'(a_kabul) + PW'(b_kabul);
    oku_ptr_d = oku_ptr_q + PW'(cek);
    sayac_d   = sayac_q + CW'(a_kabul) + CW'(b_kabul) - CW'(cek);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sayac_q   <= '0;
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      oncelik_q <= ONC_A;
    end else begin
      sayac_q   <= sayac_d;
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      oncelik_q <= oncelik_d;
    end
  end

  // Payload storage carries no reset; the pointers decide what is live.
  always_ff @(posedge clk_i) begin
    kayit_q <= kayit_d;
  end

`ifdef DALLANMA_SAYAC_EN
  logic [31:0] toplam_q, toplam_d;
  logic [31:0] atladi_q, atladi_d;
  logic [31:0] hata_q, hata_d;

  always_comb begin
    toplam_d = toplam_q;
    atladi_d = atladi_q;
    hata_d   = hata_q;
    if (cek && (toplam_q != 32'hFFFF_FFFF)) begin
      toplam_d = toplam_q + 32'd1;
    end
    if (cek && guncelle_atladi_o && (atladi_q != 32'hFFFF_FFFF)) begin
      atladi_d = atladi_q + 32'd1;
    end
    if (dallanma_hata_i && (hata_q != 32'hFFFF_FFFF)) begin
      hata_d = hata_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      toplam_q <= '0;
      atladi_q <= '0;
      hata_q   <= '0;
    end else begin
      toplam_q <= toplam_d;
      atladi_q <= atladi_d;
      hata_q   <= hata_d;
    end
  end

  assign toplam_o        = toplam_q;
  assign atladi_sayisi_o = atladi_q;
  assign hata_sayisi_o   = hata_q;
`else
  logic unused_hata;
  assign unused_hata     = dallanma_hata_i;
  assign toplam_o        = 32'd0;
  assign atladi_sayisi_o = 32'd0;
  assign hata_sayisi_o   = 32'd0;
`endif

endmodule
